// File: rtl/drm_sdp_gen.sv
// Simple dual-port RAM with byte-lane writes, optional output register stage,
// selectable read-during-write behaviour and a post-reset clear sweep.
module drm_sdp_gen #(
    parameter int unsigned           ADDR_WIDTH   = 10,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           BYTE_SIZE    = 8,
    parameter bit                    OUTPUT_REG   = 1'b0,
    parameter bit                    RD_OCE_EN    = 1'b0,
    parameter bit                    BYPASS       = 1'b1,
    parameter bit                    CLEAR_ON_RST = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
    localparam int unsigned          BE_WIDTH     = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_oce,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BE_WIDTH-1:0]   mem_be;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  oce;

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) res[i*BYTE_SIZE +: BYTE_SIZE] = new_word[i*BYTE_SIZE +: BYTE_SIZE];
        end
        return res;
    endfunction

    // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin : fsm_next
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (&clr_cnt_q) state_d = ST_RUN;
        end
    end

    // The sweep owns the write port while clearing; user writes are dropped then and during rst.
    always_comb begin : write_port
        wr_fire   = !rst && (state_q == ST_RUN) && wr_en;
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_be    = wr_byte_en;
        if (!rst && (state_q == ST_CLEAR)) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = CLEAR_VALUE;
            mem_be    = '1;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: the array has no reset; it is initialised by the clear sweep (or intentionally kept), so it still maps onto RAM.
    always_ff @(posedge clk) begin : mem_write
        if (mem_we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (mem_be[i]) mem[mem_addr][i*BYTE_SIZE +: BYTE_SIZE] <= mem_wdata[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    always_comb begin : read_path
        rd_fire = !rst && (state_q == ST_RUN) && rd_en;
        rd_word = mem[rd_addr];
        if (BYPASS && wr_fire && (wr_addr == rd_addr)) begin
            rd_word = merge_lanes(rd_word, wr_data, wr_byte_en);
        end
        s1_valid_d = rd_fire;
        s1_data_d  = rd_fire ? rd_word : s1_data_q;

        // A stage-1 word that meets a closed output enable is dropped, not stalled.
        oce         = RD_OCE_EN ? rd_oce : 1'b1;
        out_valid_d = oce && s1_valid_q;
        out_data_d  = out_valid_d ? s1_data_q : out_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state_q     <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rd_data   = OUTPUT_REG ? out_data_q : s1_data_q;
    assign rd_valid  = OUTPUT_REG ? out_valid_q : s1_valid_q;
    assign init_busy = (state_q == ST_CLEAR);

endmodule
